// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART frame parser: state encoding,
// abort cause codes and the default start-of-frame byte.
package uart_frame_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CMD  = 3'd1,
    S_LEN  = 3'd2,
    S_DATA = 3'd3,
    S_CSUM = 3'd4
  } state_t;

  localparam logic [1:0] ERR_CSUM    = 2'd1;
  localparam logic [1:0] ERR_LEN     = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  localparam logic [7:0] DEFAULT_HEADER = 8'hA5;

endpackage

// File: rtl/uart_byte_timeout.sv
// Inter-byte gap counter. It restarts on every received byte and flags
// expiry when the gap reaches TIMEOUT_CYCLES-1 while counting is enabled.
module uart_byte_timeout #(
  parameter int TIMEOUT_CYCLES = 50_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;

  // A byte in the same cycle as expiry wins: clr masks the flag.
  assign expired = en && !clr && (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr || expired) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_frame_parser.sv
// Frame decoder behind the UART receiver: header, command, length, payload,
// checksum. Streams payload bytes and reports frame completion or abort cause.
module uart_frame_parser
  import uart_frame_pkg::*;
#(
  parameter logic [7:0] HEADER         = DEFAULT_HEADER,
  parameter int         MAX_LEN        = 16,
  parameter int         TIMEOUT_CYCLES = 50_000
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [7:0] rx_data,
  input  logic       rx_vld,
  output logic [7:0] cmd,
  output logic [7:0] len,
  output logic [7:0] pl_data,
  output logic [7:0] pl_idx,
  output logic       pl_vld,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       busy
);

  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  state_t     state;
  logic [7:0] sum;
  logic [7:0] idx;
  logic       expired;

  uart_byte_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (sys_clk),
    .rst    (sys_rst),
    .clr    (rx_vld || (state == S_IDLE)),
    .en     (state != S_IDLE),
    .expired(expired)
  );

  // NOTE: every register here uses <= so all branches see the pre-edge values
  // of state, sum and idx regardless of statement order.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state     <= S_IDLE;
      sum       <= '0;
      idx       <= '0;
      cmd       <= '0;
      len       <= '0;
      pl_data   <= '0;
      pl_idx    <= '0;
      pl_vld    <= 1'b0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_code  <= '0;
      busy      <= 1'b0;
    end else begin
      // NOTE: strobes default low each cycle so every branch yields a one-cycle pulse.
      pl_vld    <= 1'b0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;

      if (state == S_IDLE) begin
        if (rx_vld && rx_data == HEADER) begin
          state <= S_CMD;
          busy  <= 1'b1;
        end
      end else if (rx_vld) begin
        case (state)
          S_CMD: begin
            cmd   <= rx_data;
            sum   <= rx_data;
            state <= S_LEN;
          end
          S_LEN: begin
            len <= rx_data;
            sum <= sum + rx_data;
            idx <= '0;
            if (rx_data > MAX_LEN_B) begin
              frame_err <= 1'b1;
              err_code  <= ERR_LEN;
              state     <= S_IDLE;
              busy      <= 1'b0;
            end else if (rx_data == 8'd0) begin
              state <= S_CSUM;
            end else begin
              state <= S_DATA;
            end
          end
          S_DATA: begin
            pl_data <= rx_data;
            pl_idx  <= idx;
            pl_vld  <= 1'b1;
            sum     <= sum + rx_data;
            idx     <= idx + 8'd1;
            if (idx == len - 8'd1) state <= S_CSUM;
          end
          S_CSUM: begin
            if (rx_data == sum) begin
              frame_ok <= 1'b1;
            end else begin
              frame_err <= 1'b1;
              err_code  <= ERR_CSUM;
            end
            state <= S_IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end else if (expired) begin
        frame_err <= 1'b1;
        err_code  <= ERR_TIMEOUT;
        state     <= S_IDLE;
        busy      <= 1'b0;
      end
    end
  end

endmodule

// File: doc/uart_frame_parser.md
# uart_frame_parser

Byte-level frame decoder directly downstream of the UART receiver. Consumes one received byte per `rx_vld` pulse and recognises frames of the form header, command, length, payload, checksum. It streams payload bytes out with their index and, at frame end, flags the frame as good or reports an error code. Frame-level control logic (register writes, DDS/ADC configuration) sits behind it and must commit a frame's payload only on `frame_ok`.

## Interface
- `HEADER`, default 8'hA5: start-of-frame byte.
- `MAX_LEN`, default 16: largest legal payload length in bytes, range 0..255.
- `TIMEOUT_CYCLES`, default 50_000 (1 ms at 50 MHz): maximum idle gap allowed between bytes inside a frame.

- `sys_clk`, in, 1: system clock, 50 MHz.
- `sys_rst`, in, 1: asynchronous, active-high reset.
- `rx_data`, in, 8: received byte, sampled only when `rx_vld` = 1.
- `rx_vld`, in, 1: one-cycle pulse per received byte; back-to-back pulses are legal.
- `cmd`, out, 8: command byte of the current or last frame.
- `len`, out, 8: length byte of the current or last frame.
- `pl_data`, out, 8: payload byte.
- `pl_idx`, out, 8: index of `pl_data`, 0-based.
- `pl_vld`, out, 1: one-cycle strobe; `pl_data` and `pl_idx` are valid while it is high.
- `frame_ok`, out, 1: one-cycle pulse when a frame completes with a correct checksum.
- `frame_err`, out, 1: one-cycle pulse when a frame is aborted.
- `err_code`, out, 2: cause of the last abort, held until the next abort. 1 = checksum mismatch, 2 = length > `MAX_LEN`, 3 = timeout.
- `busy`, out, 1: high in every state except IDLE.

## Operation
- States: IDLE, CMD, LEN, DATA, CSUM.
- IDLE:
  - A byte equal to `HEADER` moves to CMD.
  - Any other byte is ignored.
- CMD:
  - The byte is latched into `cmd`.
  - `sum` is set to that byte.
  - Next state is LEN.
- LEN:
  - The byte is latched into `len`.
  - `sum` += byte.
  - `idx` is set to 0.
  - If the byte > `MAX_LEN`: `frame_err`, `err_code` = 2, go to IDLE.
  - If the byte = 0: go to CSUM.
  - Otherwise: go to DATA.
- DATA:
  - Each byte drives `pl_data` = byte, `pl_idx` = `idx`, `pl_vld` = 1.
  - `sum` += byte, then `idx` += 1.
  - When `idx` = `len`−1, go to CSUM.
- CSUM:
  - If the byte = `sum` (mod 256): `frame_ok`, go to IDLE.
  - Otherwise: `frame_err`, `err_code` = 1, go to IDLE.
- No resync inside a frame: a `HEADER` value received in CMD, LEN, DATA or CSUM is treated as ordinary data.
- Arithmetic: `sum` is 8 bits and wraps modulo 256; `idx` is 8 bits.
- Timeout:
  - The gap counter clears on every `rx_vld` and in IDLE.
  - It counts every cycle in the other states.
  - When it reaches `TIMEOUT_CYCLES`−1: `frame_err`, `err_code` = 3, go to IDLE.
- Simultaneous byte and timeout expiry in the same cycle: the byte wins and the counter clears.
- `cmd` and `len` hold their last values after the frame ends. They update only in CMD and LEN respectively.

## Timing
- All outputs are registered. Every output effect (`pl_vld`, `frame_ok`, `frame_err`, `cmd`/`len` update) appears one cycle after the `rx_vld` that causes it.
- `frame_ok` and `frame_err` are never high in the same cycle. At most one of `pl_vld`, `frame_ok`, `frame_err` is high per cycle.
- Reset values:
  - `cmd`, `len`, `pl_data`, `pl_idx`, `err_code`: 0.
  - `pl_vld`, `frame_ok`, `frame_err`, `busy`: 0.
  - State: IDLE; `sum`, `idx` and gap counter: 0.
- Reset asserted mid-frame discards the partial frame and produces no `frame_err` pulse.
- A header byte arriving on the cycle after `frame_ok`/`frame_err` is accepted, so back-to-back frames run with zero gap.
- `busy` rises one cycle after the header's `rx_vld` and falls in the same cycle as the `frame_ok`/`frame_err` pulse.

## Structure
- Shared package `uart_frame_pkg` holds:
  - the state encoding, 3 bits;
  - the error-code constants `ERR_CSUM` = 1, `ERR_LEN` = 2, `ERR_TIMEOUT` = 3;
  - the default `HEADER` value.
- One sub-module, `uart_byte_timeout`: gap counter with `clr` and `en` inputs and an `expired` pulse output, parameterised by `TIMEOUT_CYCLES`.
- The FSM, checksum accumulator and index counter live in the top level.

## Test plan
- Good frame: bytes A5 01 02 10 20 33 →
  - `pl_vld` twice: (idx 0, 0x10), (idx 1, 0x20);
  - `frame_ok` once; `cmd` = 0x01, `len` = 2.
- Bad checksum: A5 01 02 10 20 34 → two `pl_vld` pulses, then `frame_err` with `err_code` = 1, no `frame_ok`.
- Zero length and oversize:
  - A5 07 00 07 → `frame_ok` with no `pl_vld`.
  - A5 07 11 (with `MAX_LEN` = 16) → `frame_err` with `err_code` = 2, state returns to IDLE.
- Timeout:
  - A5 01 followed by no byte for `TIMEOUT_CYCLES` cycles → `frame_err` with `err_code` = 3.
  - A following A5 02 00 02 → `frame_ok`.
- Noise and back-to-back:
  - 00 FF 5A before a frame → ignored.
  - Two good frames with zero gap → two `frame_ok` pulses.
  - Reset asserted mid-DATA → all outputs return to 0, no error pulse.
